// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared constants and types for the parametrised register file.
//   REG_DATA_W  : default register width in bits
//   REG_ADDR_W  : default address width (depth = 2**REG_ADDR_W)
//   REG_SPECIAL : default index of the register owned by the special port
//   reg_word_t  : register data word at the default width
//   reg_addr_t  : register address at the default width
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_DATA_W  = 16;
    localparam int REG_ADDR_W  = 4;
    localparam int REG_SPECIAL = 15;

    typedef logic [REG_DATA_W-1:0] reg_word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per register, tracking results still pending from
// multi-cycle units so the hazard unit can stall decode.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset, clears all busy bits
//   lock_en    : mark lock_addr busy at the next edge (already qualified)
//   lock_addr  : register to mark busy
//   wr1_en     : general write commits this cycle (already qualified)
//   wr1_addr   : general write address
//   wr2_en     : special write commits this cycle (already qualified)
//   wr2_addr   : special register index
//   rd_addr1/2 : registers looked up for busy1/busy2
//   busy1/2    : pending flag of rd_addr1/rd_addr2, with same-cycle clear bypass
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic              wr2_en,
    input  logic [ADDR_W-1:0] wr2_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_lockVec;
    logic [DEPTH-1:0] w_wrVec;
    logic [DEPTH-1:0] w_busyNext;

    // Decode this cycle's lock and write commits into one-hot vectors.
    // A lock overrides a clear on the same register: the newly issued
    // multi-cycle op is the one still pending after the edge.
    always_comb begin
        w_lockVec = '0;
        w_wrVec   = '0;
        if (lock_en) w_lockVec[lock_addr] = 1'b1;
        if (wr1_en)  w_wrVec[wr1_addr]    = 1'b1;
        if (wr2_en)  w_wrVec[wr2_addr]    = 1'b1;
        w_busyNext = (r_busy & ~w_wrVec) | w_lockVec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // A write landing this cycle already resolves the hazard, unless a
    // fresh lock on the same register re-arms it.
    always_comb begin
        busy1 = r_busy[rd_addr1] & ~(w_wrVec[rd_addr1] & ~w_lockVec[rd_addr1]);
        busy2 = r_busy[rd_addr2] & ~(w_wrVec[rd_addr2] & ~w_lockVec[rd_addr2]);
    end

endmodule

// File: rtl/reg_file_gen.sv
// ---------------------------------------------------------------------------
// reg_file_gen
// Parametrised register file: two combinational read ports with
// write-through bypass, one general write port, a dedicated special-register
// write port and a per-register busy scoreboard.
// Optional build macro REG_FILE_ZERO_REG_EN: register 0 hardwired to zero
// (writes and locks to it dropped, reads return 0).
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   rd_addr1, rd_addr2  : read addresses; rd_data1/rd_data2 are the data
//   wr_addr/data/en     : general write port
//   sp_data, sp_wr      : special-register write port (register SPECIAL_REG)
//   lock_en, lock_addr  : mark a register busy (multi-cycle op issued)
//   rd_sp               : bypassed value of the special register
//   busy1, busy2        : pending flags for rd_addr1 / rd_addr2
// ---------------------------------------------------------------------------
module reg_file_gen
    import reg_file_pkg::*;
#(
    parameter int DATA_W      = REG_DATA_W,
    parameter int ADDR_W      = REG_ADDR_W,
    parameter int SPECIAL_REG = REG_SPECIAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] sp_data,
    input  logic              sp_wr,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_sp,
    output logic              busy1,
    output logic              busy2
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SPECIAL_REG);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_genWr;
    logic              w_spWr;
    logic              w_lockEn;

    // Qualify the raw enables once so storage, bypass and scoreboard all
    // agree on what commits. Everything is gated by reset so that nothing
    // leaks through the bypass while rst is low. When both ports target
    // the special register the general port wins, so the special port is
    // treated as not writing at all.
    always_comb begin
        w_genWr  = wr_en & rst;
        w_spWr   = sp_wr & rst;
        w_lockEn = lock_en & rst;
`ifdef REG_FILE_ZERO_REG_EN
        if (wr_addr == '0)   w_genWr  = 1'b0;
        if (SP_ADDR == '0)   w_spWr   = 1'b0;
        if (lock_addr == '0) w_lockEn = 1'b0;
`endif
        if (w_genWr && (wr_addr == SP_ADDR)) w_spWr = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_spWr)  r_mem[SP_ADDR] <= sp_data;
            if (w_genWr) r_mem[wr_addr] <= wr_data;
        end
    end

    // Bypassed read: same-cycle write data takes precedence over storage,
    // general port before special port.
    function automatic logic [DATA_W-1:0] bypassRead(
        input logic [ADDR_W-1:0] addr,
        input logic              genWr,
        input logic [ADDR_W-1:0] genAddr,
        input logic [DATA_W-1:0] genData,
        input logic              spWr,
        input logic [DATA_W-1:0] spData,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] result;
        result = stored;
        if (genWr && (genAddr == addr)) begin
            result = genData;
        end else if (spWr && (addr == SP_ADDR)) begin
            result = spData;
        end
        return result;
    endfunction

    always_comb begin
        rd_data1 = bypassRead(rd_addr1, w_genWr, wr_addr, wr_data, w_spWr, sp_data, r_mem[rd_addr1]);
        rd_data2 = bypassRead(rd_addr2, w_genWr, wr_addr, wr_data, w_spWr, sp_data, r_mem[rd_addr2]);
        rd_sp    = bypassRead(SP_ADDR,  w_genWr, wr_addr, wr_data, w_spWr, sp_data, r_mem[SP_ADDR]);
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .lock_en   (w_lockEn),
        .lock_addr (lock_addr),
        .wr1_en    (w_genWr),
        .wr1_addr  (wr_addr),
        .wr2_en    (w_spWr),
        .wr2_addr  (SP_ADDR),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_reg_file_gen.sv
// ---------------------------------------------------------------------------
// tb_reg_file_gen
// Self-checking bench for reg_file_gen at default parameters (16x16,
// special register 15). Honours REG_FILE_ZERO_REG_EN when defined.
// ---------------------------------------------------------------------------
module tb_reg_file_gen;

    localparam int SP = 15;
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [15:0] sp_data;
    logic        sp_wr;
    logic        lock_en;
    logic [3:0]  lock_addr;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic [15:0] rd_sp;
    logic        busy1;
    logic        busy2;

    int cmpCount = 0;
    int errCount = 0;
    bit chkOn    = 1'b0;

    logic [15:0] mMem  [16];
    logic        mBusy [16];

    reg_file_gen dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .sp_data   (sp_data),
        .sp_wr     (sp_wr),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_sp     (rd_sp),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an array of registers and an array of pending flags,
    // updated from the architectural rules at each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mMem[i]  <= '0;
                mBusy[i] <= 1'b0;
            end
        end else begin
            if (sp_wr && !(ZR && SP == 0)) mMem[SP] <= sp_data;
            if (wr_en && !(ZR && wr_addr == 0)) mMem[wr_addr] <= wr_data;
            for (int i = 0; i < 16; i++) begin
                if (lock_en && lock_addr == 4'(i) && !(ZR && i == 0))
                    mBusy[i] <= 1'b1;
                else if ((wr_en && wr_addr == 4'(i)) || (sp_wr && i == SP))
                    mBusy[i] <= 1'b0;
            end
        end
    end

    function automatic logic [15:0] mdlRead(input logic [3:0] a);
        if (!rst) return 16'h0000;
        if (ZR && a == 0) return 16'h0000;
        if (wr_en && wr_addr == a) return wr_data;
        if (sp_wr && a == 4'(SP)) return sp_data;
        return mMem[a];
    endfunction

    function automatic logic mdlBusy(input logic [3:0] a);
        bit wh;
        bit lh;
        if (!rst) return 1'b0;
        if (ZR && a == 0) return 1'b0;
        wh = (wr_en && wr_addr == a) || (sp_wr && a == 4'(SP));
        lh = lock_en && lock_addr == a;
        if (wh && !lh) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        if (chkOn) begin
            checkOutput("cmp_rd_data1", rd_data1, mdlRead(rd_addr1));
            checkOutput("cmp_rd_data2", rd_data2, mdlRead(rd_addr2));
            checkOutput("cmp_rd_sp",    rd_sp,    mdlRead(4'(SP)));
            checkOutput("cmp_busy1",    {15'b0, busy1}, {15'b0, mdlBusy(rd_addr1)});
            checkOutput("cmp_busy2",    {15'b0, busy2}, {15'b0, mdlBusy(rd_addr2)});
        end
    end

    task automatic applyStimulus(
        input logic        rstV,
        input logic        we,
        input logic [3:0]  wa,
        input logic [15:0] wd,
        input logic        se,
        input logic [15:0] sd,
        input logic        le,
        input logic [3:0]  la,
        input logic [3:0]  ra1,
        input logic [3:0]  ra2
    );
        @(posedge clk);
        #1;
        rst       = rstV;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        sp_wr     = se;
        sp_data   = sd;
        lock_en   = le;
        lock_addr = la;
        rd_addr1  = ra1;
        rd_addr2  = ra2;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sp_wr = 1'b0; sp_data = '0;
        lock_en = 1'b0; lock_addr = '0;
        rd_addr1 = 4'd1; rd_addr2 = 4'd15;
        #1;
        rst = 1'b0;
        // Writes and locks driven during reset must be ignored.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF;
        sp_wr = 1'b1; sp_data = 16'h5555;
        lock_en = 1'b1; lock_addr = 4'd1;
        chkOn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("reset_rd1",   rd_data1, 16'h0000);
        checkOutput("reset_rd2",   rd_data2, 16'h0000);
        checkOutput("reset_sp",    rd_sp,    16'h0000);
        checkOutput("reset_busy1", {15'b0, busy1}, 16'h0000);
        checkOutput("reset_busy2", {15'b0, busy2}, 16'h0000);

        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("post_reset_rd1",   rd_data1, 16'h0000);
        checkOutput("post_reset_busy1", {15'b0, busy1}, 16'h0000);

        applyStimulus(1, 1, 4'd1, 16'hCCCC, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("wr_bypass_rd1", rd_data1, 16'hCCCC);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("wr_stored_rd1", rd_data1, 16'hCCCC);

        applyStimulus(1, 1, 4'd15, 16'hF0F0, 1, 16'h0F0F, 0, 0, 4'd1, 4'd15);
        checkOutput("conflict_sp_bypass",  rd_sp,    16'hF0F0);
        checkOutput("conflict_rd2_bypass", rd_data2, 16'hF0F0);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("conflict_sp_stored",  rd_sp,    16'hF0F0);

        applyStimulus(1, 0, 0, 16'h0, 1, 16'h1357, 0, 0, 4'd1, 4'd15);
        checkOutput("sp_bypass", rd_sp, 16'h1357);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("sp_stored_rd2", rd_data2, 16'h1357);

        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 1, 4'd3, 4'd3, 4'd15);
        checkOutput("lock_same_cycle_busy1", {15'b0, busy1}, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd3, 4'd15);
        checkOutput("lock_next_busy1", {15'b0, busy1}, 16'h0001);
        applyStimulus(1, 1, 4'd3, 16'hAAAA, 0, 16'h0, 0, 0, 4'd3, 4'd15);
        checkOutput("clear_bypass_busy1", {15'b0, busy1}, 16'h0000);
        checkOutput("clear_bypass_rd1",   rd_data1, 16'hAAAA);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd3, 4'd15);
        checkOutput("clear_stored_busy1", {15'b0, busy1}, 16'h0000);
        checkOutput("clear_stored_rd1",   rd_data1, 16'hAAAA);

        applyStimulus(1, 1, 4'd2, 16'hBBBB, 0, 16'h0, 1, 4'd2, 4'd2, 4'd2);
        checkOutput("lockwr_rd1",   rd_data1, 16'hBBBB);
        checkOutput("lockwr_rd2",   rd_data2, 16'hBBBB);
        checkOutput("lockwr_busy1", {15'b0, busy1}, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd2, 4'd2);
        checkOutput("lockwr_after_rd1",   rd_data1, 16'hBBBB);
        checkOutput("lockwr_after_busy1", {15'b0, busy1}, 16'h0001);
        checkOutput("lockwr_after_busy2", {15'b0, busy2}, 16'h0001);

        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 1, 4'd3, 4'd3, 4'd2);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 1, 4'd3, 4'd3, 4'd2);
        checkOutput("relock_busy1", {15'b0, busy1}, 16'h0001);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd3, 4'd2);
        checkOutput("prereset_busy1", {15'b0, busy1}, 16'h0001);
        checkOutput("prereset_busy2", {15'b0, busy2}, 16'h0001);

        // Asynchronous reset between edges.
        #1;
        rst = 1'b0;
        rd_addr1 = 4'd1;
        #1;
        checkOutput("async_rd1",   rd_data1, 16'h0000);
        checkOutput("async_rd2",   rd_data2, 16'h0000);
        checkOutput("async_sp",    rd_sp,    16'h0000);
        checkOutput("async_busy2", {15'b0, busy2}, 16'h0000);
        rd_addr1 = 4'd3;
        #1;
        checkOutput("async_busy1", {15'b0, busy1}, 16'h0000);

        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("resume_rd1", rd_data1, 16'h0000);
        applyStimulus(1, 1, 4'd1, 16'h6666, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd1, 4'd15);
        checkOutput("resume_wr_rd1", rd_data1, 16'h6666);

        applyStimulus(1, 1, 4'd0, 16'h1234, 0, 16'h0, 1, 4'd0, 4'd0, 4'd15);
        checkOutput("zero_bypass_rd1", rd_data1, ZR ? 16'h0000 : 16'h1234);
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'd0, 4'd15);
        checkOutput("zero_stored_rd1", rd_data1, ZR ? 16'h0000 : 16'h1234);
        checkOutput("zero_busy1", {15'b0, busy1}, ZR ? 16'h0000 : 16'h0001);

        // Sweep of mixed writes, special writes and locks checked by the model.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1'b1, 4'(i), 16'(i * 16'h1111) ^ 16'h00FF,
                          i[1], 16'(i * 3), i[0], 4'((i + 5) % 16),
                          4'(i), 4'((i + 5) % 16));
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 4'(i), 4'(15 - i));
        end

        @(negedge clk);
        #1;
        chkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/reg_file_gen.md
Name: reg_file_gen

Overview:
- Parametrised successor to the 16x16 register file.
- Configurable width and depth; two combinational read ports; one general write port; a dedicated special-register write/read port (default R15, used for multiply-high/remainder results).
- Adds write-through bypass and a per-register busy scoreboard, so the decode stage can stall on results still pending from multi-cycle units.
- Sits between decode (read addresses), writeback (write ports) and the hazard unit (busy flags).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- SPECIAL_REG, 15, index of the register written by the special port; must be < 2**ADDR_W

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- wr_addr  input  ADDR_W  general write address
- wr_data  input  DATA_W  general write data
- wr_en  input  1  general write enable
- sp_data  input  DATA_W  special-register write data
- sp_wr  input  1  special-register write enable
- lock_en  input  1  mark lock_addr busy (multi-cycle op issued)
- lock_addr  input  ADDR_W  register to mark busy
- rd_data1  output  DATA_W  read port 1 data
- rd_data2  output  DATA_W  read port 2 data
- rd_sp  output  DATA_W  current special-register value (bypassed)
- busy1  output  1  register at rd_addr1 pending
- busy2  output  1  register at rd_addr2 pending

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0. Hence rd_data1/2, rd_sp and busy1/2 read 0 during and after reset until written. Writes and locks are ignored while rst=0. Deasserting reset mid-sequence resumes cleanly at the next edge.
- Writes: commit on rising clk edge. General: mem[wr_addr] <= wr_data when wr_en. Special: mem[SPECIAL_REG] <= sp_data when sp_wr.
- Write conflict: wr_en with wr_addr==SPECIAL_REG and sp_wr in the same cycle -> the general port wins; sp_data is discarded.
- Reads: combinational, zero-cycle latency, with write-through bypass.
  - If rd_addrN matches a register being written this cycle, rd_dataN = the winning write data, not the stored value.
  - Bypass follows the same priority as the write conflict rule.
  - rd_sp is bypassed the same way.
  - Both read ports may address the same register; both return identical data.
- Scoreboard: one busy bit per register.
  - Set at the clock edge when lock_en=1 for lock_addr.
  - Cleared at the clock edge by any committed write to that register, from either port.
  - Lock and write to the same register in the same cycle -> busy is set (the new pending op wins); the write data still commits.
  - busyN = busy[rd_addrN], except it reads 0 when a write to rd_addrN commits this cycle and no same-cycle lock targets it (bypassed clear).
  - Locking an already-busy register keeps it busy; no counting.
- Out-of-range index is impossible by construction (depth = 2**ADDR_W).

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - Writes to address 0 are dropped on both ports.
  - Reads of address 0 return 0, including bypass.
  - lock_en to address 0 is ignored; busy bit 0 is constantly 0.
  - If SPECIAL_REG==0, sp_wr has no effect.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W, ADDR_W and SPECIAL_REG constants
  - a typedef for the register data word
  - a typedef for the register address
- One sub-module: reg_scoreboard. It holds the busy-bit vector with set/clear/priority logic and the busy1/busy2 lookups. It takes clk, rst, lock_en, lock_addr, the effective write-commit addresses/enables, and rd_addr1/2.
- Storage array and bypass muxes stay in reg_file_gen.

Test Plan:
- Reset then read: rst=0 for 2 cycles, rd_addr1=1, rd_addr2=15 -> rd_data1=0000, rd_data2=0000, rd_sp=0000, busy1=busy2=0.
- Write then read: wr_en=1, wr_addr=1, wr_data=CCCC. Same cycle rd_addr1=1 -> rd_data1=CCCC (bypass). After the edge with wr_en=0 -> still CCCC.
- Port conflict: wr_en=1, wr_addr=15, wr_data=F0F0 and sp_wr=1, sp_data=0F0F -> rd_sp=F0F0 that cycle; mem[15]=F0F0 after the edge.
- Scoreboard: lock_en=1, lock_addr=3 -> busy1=1 for rd_addr1=3 from the next cycle. Later wr_en to 3 with data AAAA -> busy1=0 in that cycle and stays 0; rd_data1=AAAA.
- Simultaneous lock and write to 2 (data BBBB) -> mem[2]=BBBB, busy bit 2 remains set after the edge.
- Async reset mid-operation: registers 1/2/15 loaded, busy bit 3 set. Pull rst low between edges -> all reads 0 and busy=0 immediately, without waiting for a clock edge.
- With REG_FILE_ZERO_REG_EN defined, an additional run: write 1234 to address 0 -> rd_data1 with rd_addr1=0 reads 0000.
